// File: rtl/data_mem_if.sv
// data_mem_if: request/response channels between a load/store unit and its data memory.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_bytes;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    modport master(
        output req_valid, req_store, req_bytes, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave(
        input  req_valid, req_store, req_bytes, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding word-organised data memory with byte/half/word
// access, optional fixed stall and error responses for misaligned/out-of-range/illegal requests.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input logic       clk,
    input logic       rst,
    data_mem_if.slave bus
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int AW = IW + 2;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t         state;
    logic [3:0]     cnt;
    logic           cap_store;
    logic [1:0]     cap_bytes;
    logic [AW-1:0]  cap_addr;
    logic [31:0]    cap_wdata;
    logic [31:0]    mem [DEPTH_WORDS];
    logic           bad;
    logic           a_store;
    logic [1:0]     a_bytes;
    logic [AW-1:0]  a_addr;
    logic [31:0]    a_wdata;
    logic [IW-1:0]  idx;
    logic [3:0]     lanes;
    logic [31:0]    wrep;
    logic [31:0]    shifted;
    logic [31:0]    load_data;
    logic           access;
    logic           we;
    // In IDLE the access fields come straight from the bus so a zero-wait build can act in the accept cycle.
    always_comb begin
        bad = bus.req_bytes == 2'd3 || (bus.req_bytes == 2'd1 && bus.req_addr[0]) ||
              (bus.req_bytes == 2'd2 && bus.req_addr[1:0] != 2'd0) ||
              {2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS);
        a_store = state == IDLE ? bus.req_store : cap_store;
        a_bytes = state == IDLE ? bus.req_bytes : cap_bytes;
        a_addr = state == IDLE ? bus.req_addr[AW-1:0] : cap_addr;
        a_wdata = state == IDLE ? bus.req_wdata : cap_wdata;
        idx = a_addr[AW-1:2];
        lanes = a_bytes == 2'd0 ? 4'b0001 << a_addr[1:0] : a_bytes == 2'd1 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wrep = a_bytes == 2'd0 ? {4{a_wdata[7:0]}} : a_bytes == 2'd1 ? {2{a_wdata[15:0]}} : a_wdata;
        shifted = mem[idx] >> {a_addr[1:0], 3'b000};
        load_data = a_bytes == 2'd0 ? {24'b0, shifted[7:0]} : a_bytes == 2'd1 ? {16'b0, shifted[15:0]} : shifted;
        access = WAIT_CYCLES == 0 ? state == IDLE && bus.req_valid && !bad : state == WAIT && cnt == 4'd0;
        we = access && a_store && !rst;
    end
    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < 4; i++)
                if (lanes[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= 4'd0;
            cap_store <= 1'b0;
            cap_bytes <= 2'd0;
            cap_addr <= '0;
            cap_wdata <= '0;
            bus.req_ready <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    cap_store <= bus.req_store;
                    cap_bytes <= bus.req_bytes;
                    cap_addr <= bus.req_addr[AW-1:0];
                    cap_wdata <= bus.req_wdata;
                    bus.req_ready <= 1'b0;
                    if (bad || WAIT_CYCLES == 0) begin
                        state <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err <= bad;
                        bus.resp_rdata <= bad || bus.req_store ? '0 : load_data;
                    end else begin
                        state <= WAIT;
                        cnt <= 4'(WAIT_CYCLES - 1);
                    end
                end
                WAIT: if (cnt == 4'd0) begin
                    state <= RESP;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= cap_store ? '0 : load_data;
                end else cnt <= cnt - 4'd1;
                RESP: if (bus.resp_ready) begin
                    state <= IDLE;
                    bus.req_ready <= 1'b1;
                    bus.resp_valid <= 1'b0;
                    bus.resp_rdata <= '0;
                    bus.resp_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
